// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and dmem.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] adr0;
  logic [AW-1:0] adr1;
  logic [31:0]   wd0;
  logic [31:0]   wd1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [31:0]   rd0;
  logic [31:0]   rd1;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;
  logic          misalign;

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wd0, wd1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rd0, rd1,
           mem_we, mem_adr, mem_wd, misalign
  );

  modport master (
    output req0, req1, we0, we1, adr0, adr1, wd0, wd1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rd0, rd1,
           mem_we, mem_adr, mem_wd, misalign
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-bounded two-port arbiter in front of the single-ported dmem.
// Optional grant/wait statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   gcnt0,
  output logic [31:0]   gcnt1,
  output logic [31:0]   wcnt
`endif
);

  localparam int             CW       = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          last_q;
  logic          last_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic          req0_s;
  logic          req1_s;
  logic          gnt0_s;
  logic          gnt1_s;
  logic          own_id_s;
  logic          own_req_s;
  logic          oth_req_s;
  logic [AW-1:0] adr0_s;
  logic [AW-1:0] adr1_s;
  logic [AW-1:0] mem_adr_s;
  logic [31:0]   mem_wd_s;
  logic          mem_we_s;

  logic          rvalid0_q;
  logic          rvalid1_q;
  logic [31:0]   rd0_q;
  logic [31:0]   rd1_q;

  assign req0_s = bus.req0;
  assign req1_s = bus.req1;
  assign adr0_s = bus.adr0;
  assign adr1_s = bus.adr1;

  assign gnt0_s = (state_q == OWN0) & req0_s;
  assign gnt1_s = (state_q == OWN1) & req1_s;

  // View of the current owner and its competitor, used by the next-state logic.
  always_comb begin
    own_id_s  = 1'b0;
    own_req_s = 1'b0;
    oth_req_s = 1'b0;
    if (state_q == OWN1) begin
      own_id_s  = 1'b1;
      own_req_s = req1_s;
      oth_req_s = req0_s;
    end else begin
      own_id_s  = 1'b0;
      own_req_s = req0_s;
      oth_req_s = req1_s;
    end
  end

  // Next-state, last-owner and burst-counter computation.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (req0_s && req1_s) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (req0_s) begin
          state_d = OWN0;
        end else if (req1_s) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (oth_req_s && (!own_req_s || (cnt_q == CNT_LAST))) begin
          // Handover goes straight to the other OWN state, no idle bubble.
          state_d = own_id_s ? OWN0 : OWN1;
          cnt_d   = {CW{1'b0}};
          last_d  = own_id_s;
        end else if (!own_req_s) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
          last_d  = own_id_s;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        last_d  = 1'b1;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory-side mux; port 0 values are presented when nobody is granted.
  always_comb begin
    mem_adr_s = adr0_s;
    mem_wd_s  = bus.wd0;
    mem_we_s  = 1'b0;
    if (gnt1_s) begin
      mem_adr_s = adr1_s;
      mem_wd_s  = bus.wd1;
      mem_we_s  = bus.we1;
    end else if (gnt0_s) begin
      mem_adr_s = adr0_s;
      mem_wd_s  = bus.wd0;
      mem_we_s  = bus.we0;
    end else begin
      mem_adr_s = adr0_s;
      mem_wd_s  = bus.wd0;
      mem_we_s  = 1'b0;
    end
  end

  // Read-data capture; rd holds until the next read on the same port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rd0_q     <= 32'h0000_0000;
      rd1_q     <= 32'h0000_0000;
    end else begin
      rvalid0_q <= gnt0_s & ~bus.we0;
      rvalid1_q <= gnt1_s & ~bus.we1;
      if (gnt0_s && !bus.we0) begin
        rd0_q <= bus.mem_rd;
      end else begin
        rd0_q <= rd0_q;
      end
      if (gnt1_s && !bus.we1) begin
        rd1_q <= bus.mem_rd;
      end else begin
        rd1_q <= rd1_q;
      end
    end
  end

  assign bus.gnt0     = gnt0_s;
  assign bus.gnt1     = gnt1_s;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rd0      = rd0_q;
  assign bus.rd1      = rd1_q;
  assign bus.mem_we   = mem_we_s;
  assign bus.mem_adr  = mem_adr_s;
  assign bus.mem_wd   = mem_wd_s;
  // Misaligned accesses are forwarded untouched and only flagged.
  assign bus.misalign = (gnt0_s | gnt1_s) & (mem_adr_s[1:0] != 2'b00);

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] gcnt0_q;
  logic [31:0] gcnt1_q;
  logic [31:0] wcnt_q;
  logic        wait_s;

  assign wait_s = (req0_s & ~gnt0_s) | (req1_s & ~gnt1_s);

  // Wrapping grant and wait cycle counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcnt0_q <= 32'd0;
      gcnt1_q <= 32'd0;
      wcnt_q  <= 32'd0;
    end else begin
      gcnt0_q <= gcnt0_q + {31'd0, gnt0_s};
      gcnt1_q <= gcnt1_q + {31'd0, gnt1_s};
      wcnt_q  <= wcnt_q + {31'd0, wait_s};
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
  assign wcnt  = wcnt_q;
`endif

endmodule
